multi_16bit: RTL and testbench

Sequential unsigned 16×16 multiplier producing a 32-bit product using a shift-and-add datapath, one partial product per clock. It sits beside the arithmetic datapath as a low-area alternative to a combinational multiplier. Operation starts on a `start` request and completes with a one-cycle `done` pulse. The product stays held on `yout` until the next operation completes.

---
 rtl/multi_16bit.sv | 99 +++++++++
 tb/tb_multi_16bit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/multi_16bit.sv
// Sequential unsigned 16x16 shift-and-add multiplier, one partial product per clock.
// A start in IDLE captures the operands; done pulses for one cycle with the product on yout.
module multi_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] ain,
    input  logic [15:0] bin,
    output logic [31:0] yout,
    output logic        done
);

    localparam int unsigned AW = 16;
    localparam int unsigned PW = 32;
    localparam int unsigned CW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(AW - 1);

    logic [1:0]    state, state_nxt;
    logic [PW-1:0] a_r, a_nxt;
    logic [AW-1:0] b_r, b_nxt;
    logic [PW-1:0] acc, acc_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [PW-1:0] yout_nxt;
    logic          done_nxt;

    logic [PW-1:0] addend;
    logic [PW-1:0] acc_sum;

    // Partial product for the current multiplier LSB; the sum cannot exceed 0xFFFE0001.
    assign addend  = b_r[0] ? a_r : '0;
    assign acc_sum = acc + addend;

    // State and datapath registers; reset also discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            yout  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            a_r   <= a_nxt;
            b_r   <= b_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            yout  <= yout_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state and datapath update; yout only moves on the final iteration.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_r;
        b_nxt     = b_r;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        yout_nxt  = yout;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    a_nxt     = PW'(ain);
                    b_nxt     = bin;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_nxt = acc_sum;
                a_nxt   = {a_r[PW-2:0], 1'b0};
                b_nxt   = {1'b0, b_r[AW-1:1]};
                cnt_nxt = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    yout_nxt  = acc_sum;
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_16bit.sv
// Bench for multi_16bit: a cycle-level product/timing model checked every cycle,
// plus directed operations with hand-computed products and latencies.
module tb_multi_16bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ain = '0;
    logic [15:0] bin = '0;
    logic [31:0] yout;
    logic        done;

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    multi_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ain   (ain),
        .bin   (bin),
        .yout  (yout),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Model: a start accepted while free yields ain*bin 16 edges later; free again 18 edges after capture.
    longint      cyc = 0;
    longint      m_due = -1;
    longint      m_free_at = 0;
    logic [31:0] m_prod = '0;
    logic [31:0] m_yout = '0;
    logic        m_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_yout    <= '0;
            m_done    <= 1'b0;
            m_due     <= -1;
            m_free_at <= 0;
        end else begin
            m_done <= (cyc == m_due);
            if (cyc == m_due) m_yout <= m_prod;
            if (start && cyc >= m_free_at) begin
                m_prod    <= 32'(ain) * 32'(bin);
                m_due     <= cyc + 16;
                m_free_at <= cyc + 18;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // One operation; ain may be overwritten at negedge chg_at to show operands are latched.
    task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input int chg_at, input logic [15:0] chg_a);
        int lat;
        lat = 0;
        @(negedge clk);
        ain   = a;
        bin   = b;
        start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == chg_at) ain = chg_a;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({nm, " latency"}, 32'(lat - 1), 32'd16);
        chk({nm, " yout"}, yout, exp);
        chk({nm, " model"}, m_yout, exp);
        @(negedge clk);
        chk({nm, " done drop"}, 32'(done), 32'd0);
        chk({nm, " yout hold"}, yout, exp);
    endtask

    initial begin
        int          lat;
        logic [15:0] pa, pb;
        bit          seen;

        fork
            forever begin
                @(negedge clk);
                if (rst_n && mon_en) begin
                    chk("mon yout", yout, m_yout);
                    chk("mon done", 32'(done), 32'(m_done));
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset yout", yout, 32'h0);
        chk("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        run_op("p1234x5678", 16'h1234, 16'h5678, 32'h06260060, 0, 16'h0);
        run_op("pFFFFxFFFF", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 16'h0);
        run_op("p0000x1234", 16'h0000, 16'h1234, 32'h00000000, 0, 16'h0);
        run_op("p0001x8001", 16'h0001, 16'h8001, 32'h00008001, 5, 16'hFFFF);
        run_op("p00FFx0101", 16'h00FF, 16'h0101, 32'h0000FFFF, 0, 16'h0);

        // Back-to-back with start held; new operands applied right after each done.
        @(negedge clk);
        pa    = 16'($urandom);
        pb    = 16'($urandom);
        ain   = pa;
        bin   = pb;
        start = 1'b1;
        for (int k = 0; k < 100; k++) begin
            lat = 0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (done) begin
                    lat = i;
                    break;
                end
            end
            chk("b2b latency", 32'(lat), (k == 0) ? 32'd17 : 32'd18);
            chk("b2b yout", yout, 32'(pa) * 32'(pb));
            if (k < 99) begin
                pa  = 16'($urandom);
                pb  = 16'($urandom);
                ain = pa;
                bin = pb;
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        // Reset during iteration 8 clears outputs at once and cancels the result.
        @(negedge clk);
        ain   = 16'hABCD;
        bin   = 16'h1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst yout", yout, 32'h0);
        chk("async rst done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("no done after rst", 32'(seen), 32'd0);
        chk("yout after rst", yout, 32'h0);

        run_op("p3x5", 16'd3, 16'd5, 32'h0000000F, 0, 16'h0);

        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
